// File: rtl/btn_conditioner_array.sv
// -----------------------------------------------------------------------------
// btn_conditioner_array
//
// N-channel push-button front end. Each channel has its own synchroniser,
// debouncer and press/hold event generator. Channels share no state.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-low
//   i_btn        raw asynchronous button inputs, active-high
//   i_repeat_en  per-channel auto-repeat enable, applied combinationally
//   o_level      debounced level
//   o_press      1-cycle pulse in the first cycle o_level is 1
//   o_release    1-cycle pulse in the first cycle o_level is 0
//   o_long       1-cycle pulse LONG_CYCLES cycles after o_press
//   o_repeat     auto-repeat pulses (first one coincides with o_long)
// -----------------------------------------------------------------------------
module btn_conditioner_array #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 100000,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  // A one-cycle repeat period still needs a 1-bit counter to exist.
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : ch_g
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [DB_W-1:0]        db_cnt_reg;
      logic [HOLD_W-1:0]      hold_cnt_reg;
      logic [REP_W-1:0]       rep_cnt_reg;
      state_t                 state_reg;
      logic                   level_reg;
      logic                   press_reg;
      logic                   release_reg;
      logic                   long_reg;
      logic                   tick_reg;
      logic                   s;
      logic                   accept;

      assign s = sync_reg[SYNC_STAGES-1];
      // The synchronised input has differed from the level long enough.
      assign accept = (s != level_reg) && (db_cnt_reg == DB_LAST);

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_reg     <= '0;
          db_cnt_reg   <= '0;
          hold_cnt_reg <= '0;
          rep_cnt_reg  <= '0;
          state_reg    <= IDLE;
          level_reg    <= 1'b0;
          press_reg    <= 1'b0;
          release_reg  <= 1'b0;
          long_reg     <= 1'b0;
          tick_reg     <= 1'b0;
        end else begin
          sync_reg    <= {sync_reg[SYNC_STAGES-2:0], i_btn[gi]};
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          long_reg    <= 1'b0;
          tick_reg    <= 1'b0;

          // Debounce: any cycle matching the current level restarts the count.
          if (s == level_reg) begin
            db_cnt_reg <= '0;
          end else if (accept) begin
            db_cnt_reg <= '0;
            level_reg  <= s;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end

          // An accepted fall overrides everything, so no long/repeat pulse
          // can share a cycle with o_release.
          if (accept && !s) begin
            state_reg   <= IDLE;
            release_reg <= 1'b1;
          end else if (accept && s) begin
            state_reg    <= PRESSED;
            press_reg    <= 1'b1;
            hold_cnt_reg <= '0;
          end else begin
            case (state_reg)
              PRESSED: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                  // hold_cnt parks at LONG_CYCLES so o_long never re-fires.
                  hold_cnt_reg <= HOLD_MAX;
                  long_reg     <= 1'b1;
                  tick_reg     <= 1'b1;
                  rep_cnt_reg  <= '0;
                  state_reg    <= HELD;
                end else begin
                  hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                end
              end
              HELD: begin
                if (rep_cnt_reg == REP_LAST) begin
                  rep_cnt_reg <= '0;
                  tick_reg    <= 1'b1;
                end else begin
                  rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
                end
              end
              default: begin
              end
            endcase
          end
        end
      end

      assign o_level[gi]   = level_reg;
      assign o_press[gi]   = press_reg;
      assign o_release[gi] = release_reg;
      assign o_long[gi]    = long_reg;
      // Enable only masks the tick; the repeat phase keeps running underneath.
      assign o_repeat[gi]  = tick_reg & i_repeat_en[gi];
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner_array.sv
// -----------------------------------------------------------------------------
// Testbench for btn_conditioner_array (N_CH=4, SYNC_STAGES=2, DB_CYCLES=4,
// LONG_CYCLES=20, REPEAT_CYCLES=5). Expected pulse events are queued with
// their cycle number when stimulus is driven; a negedge monitor pops the
// events due in the current cycle and compares every output each cycle.
// -----------------------------------------------------------------------------
module tb_btn_conditioner_array;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int LC  = 20;
  localparam int RC  = 5;
  localparam int LAT = SS + DB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] i_repeat_en = '0;
  logic [N-1:0] o_level, o_press, o_release, o_long, o_repeat;

  btn_conditioner_array #(
    .N_CH(N), .SYNC_STAGES(SS), .DB_CYCLES(DB),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_repeat_en(i_repeat_en),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] rep;
    bit           clr;
  } ev_t;

  typedef struct {
    int ch;
    bit en;
    int hold;
    bit exp_press;
    int long_off;
    int nrep;
  } vec_t;

  ev_t          sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_level = '0;
  bit           mon_en = 1'b0;

  task automatic add_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] l, input logic [N-1:0] rp, input bit clr);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.rep = rp; e.clr = clr;
    sb_q.push_back(e);
  endtask

  task automatic check4(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [N-1:0] ep, er, el, erp;
    bit           clr;
    if (mon_en) begin
      ep = '0; er = '0; el = '0; erp = '0; clr = 1'b0;
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
        if (sb_q[k].cyc == cyc) begin
          ep  = ep  | sb_q[k].press;
          er  = er  | sb_q[k].rel;
          el  = el  | sb_q[k].lng;
          erp = erp | sb_q[k].rep;
          clr = clr | sb_q[k].clr;
          sb_q.delete(k);
        end
      end
      if (clr) exp_level = '0;
      exp_level = (exp_level | ep) & ~er;
      check4("level",   o_level,   exp_level);
      check4("press",   o_press,   ep);
      check4("release", o_release, er);
      check4("long",    o_long,    el);
      check4("repeat",  o_repeat,  erp);
    end
  end

  vec_t         vec[9];
  int           t, p, ch;
  logic [N-1:0] oh;

  initial begin
    // ch, en, hold, press?, long offset after press (-1 none), repeat count
    vec[0] = '{0, 1'b1,  3, 1'b0, -1, 0};  // glitch shorter than debounce
    vec[1] = '{0, 1'b1,  4, 1'b1, -1, 0};  // shortest accepted press
    vec[2] = '{1, 1'b1, 12, 1'b1, -1, 0};  // short press
    vec[3] = '{2, 1'b1, 41, 1'b1, 20, 5};  // repeats at +20,+25,+30,+35,+40
    vec[4] = '{2, 1'b1, 40, 1'b1, 20, 4};  // repeat tick lands on release cycle
    vec[5] = '{3, 1'b1, 20, 1'b1, -1, 0};  // release on the would-be long cycle
    vec[6] = '{3, 1'b1, 21, 1'b1, 20, 1};  // release one cycle after long
    vec[7] = '{0, 1'b0, 30, 1'b1, 20, 0};  // repeat masked
    vec[8] = '{1, 1'b1, 27, 1'b1, 20, 2};

    rst = 1'b0;
    step();
    mon_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 9; i++) begin
      ch = vec[i].ch;
      oh = 4'b0001 << ch;
      i_repeat_en[ch] = vec[i].en;
      t = cyc;
      p = t + LAT;
      if (vec[i].exp_press) begin
        add_ev(p, oh, '0, '0, '0, 1'b0);
        add_ev(t + vec[i].hold + LAT, '0, oh, '0, '0, 1'b0);
        if (vec[i].long_off >= 0) add_ev(p + vec[i].long_off, '0, '0, oh, '0, 1'b0);
        for (int k = 0; k < vec[i].nrep; k++) add_ev(p + LC + k * RC, '0, '0, '0, oh, 1'b0);
      end
      i_btn[ch] = 1'b1;
      repeat (vec[i].hold) step();
      i_btn[ch] = 1'b0;
      repeat (12) step();
      i_repeat_en = '0;
    end

    // Enable raised mid-hold: the tick phase is unchanged.
    t = cyc; p = t + LAT;
    add_ev(p, 4'b0100, '0, '0, '0, 1'b0);
    add_ev(p + LC, '0, '0, 4'b0100, '0, 1'b0);
    add_ev(p + 30, '0, '0, '0, 4'b0100, 1'b0);
    add_ev(p + 35, '0, '0, '0, 4'b0100, 1'b0);
    add_ev(p + 40, '0, '0, '0, 4'b0100, 1'b0);
    add_ev(p + 45, '0, 4'b0100, '0, '0, 1'b0);
    i_btn[2] = 1'b1;
    repeat (33) step();
    i_repeat_en[2] = 1'b1;
    repeat (12) step();
    i_btn[2] = 1'b0;
    repeat (12) step();
    i_repeat_en = '0;

    // All channels together, then channel 3 released alone.
    i_repeat_en = 4'hF;
    t = cyc;
    add_ev(t + LAT, 4'b1111, '0, '0, '0, 1'b0);
    add_ev(t + 10 + LAT, '0, 4'b1000, '0, '0, 1'b0);
    add_ev(t + 15 + LAT, '0, 4'b0111, '0, '0, 1'b0);
    i_btn = 4'b1111;
    repeat (10) step();
    i_btn[3] = 1'b0;
    repeat (5) step();
    i_btn = '0;
    repeat (12) step();

    // Reset while channel 2 is in HELD, button still pressed.
    i_repeat_en = 4'b0100;
    t = cyc; p = t + LAT;
    add_ev(p, 4'b0100, '0, '0, '0, 1'b0);
    add_ev(p + LC, '0, '0, 4'b0100, 4'b0100, 1'b0);
    add_ev(p + 23, '0, '0, '0, '0, 1'b1);
    add_ev(p + 23 + LAT, 4'b0100, '0, '0, '0, 1'b0);
    add_ev(p + 33 + LAT, '0, 4'b0100, '0, '0, 1'b0);
    i_btn[2] = 1'b1;
    repeat (28) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (10) step();
    i_btn[2] = 1'b0;
    repeat (15) step();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
